// File: rtl/ccff_bitstream_loader.sv
// rtl/ccff_bitstream_loader.sv - serializes bitstream words into the ccff_head configuration chain.
// Optional chain readback verification is enabled by defining CCFF_READBACK_EN.
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 20,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int WC_W = $clog2(WORD_W + 1);
  localparam logic [WC_W-1:0]  WLAST = WC_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CLAST = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SHIFT, S_VERIFY, S_FINISH} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bcnt_q, bcnt_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic              head_q, head_d;
  logic              shen_q, shen_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
`ifdef CCFF_READBACK_EN
  logic [CHAIN_LEN-1:0] store_q, store_d;
  logic                 vchk_q, vchk_d;
`else
  logic                 unused_tail;
  assign unused_tail = ccff_tail;
`endif

  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      wcnt_q  <= '0;
      shreg_q <= '0;
      head_q  <= 1'b0;
      shen_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
`ifdef CCFF_READBACK_EN
      store_q <= '0;
      vchk_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      wcnt_q  <= wcnt_d;
      shreg_q <= shreg_d;
      head_q  <= head_d;
      shen_q  <= shen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
`ifdef CCFF_READBACK_EN
      store_q <= store_d;
      vchk_q  <= vchk_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    wcnt_d  = wcnt_q;
    shreg_d = shreg_q;
    head_d  = head_q;
    shen_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = error_q;
`ifdef CCFF_READBACK_EN
    store_d = store_q;
    vchk_d  = 1'b0;
    // The bit registered one cycle ago has just reached the tail on this enabled edge.
    if (vchk_q && (ccff_tail != store_q[CHAIN_LEN-1])) error_d = 1'b1;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          busy_d  = 1'b1;
          bcnt_d  = '0;
          error_d = 1'b0;
        end
      end
      S_FETCH: begin
        wcnt_d = '0;
        if (word_valid) begin
          shreg_d = word_in;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        head_d  = shreg_q[0];
        shen_d  = 1'b1;
        shreg_d = shreg_q >> 1;
        bcnt_d  = bcnt_q + CNT_W'(1);
        wcnt_d  = wcnt_q + WC_W'(1);
`ifdef CCFF_READBACK_EN
        store_d = store_q >> 1;
        store_d[CHAIN_LEN-1] = shreg_q[0];
`endif
        if (bcnt_q == CLAST) begin
          bcnt_d = '0;
`ifdef CCFF_READBACK_EN
          state_d = S_VERIFY;
`else
          state_d = S_FINISH;
`endif
        end else if (wcnt_q == WLAST) begin
          state_d = S_FETCH;
        end
      end
`ifdef CCFF_READBACK_EN
      S_VERIFY: begin
        // One extra cycle after the last re-shift lets the final tail bit be checked.
        if (bcnt_q == CNT_W'(CHAIN_LEN)) begin
          state_d = S_FINISH;
        end else begin
          head_d  = store_q[0];
          shen_d  = 1'b1;
          vchk_d  = 1'b1;
          bcnt_d  = bcnt_q + CNT_W'(1);
          store_d = store_q >> 1;
          store_d[CHAIN_LEN-1] = store_q[0];
        end
      end
`endif
      S_FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign word_ready    = (state_q == S_FETCH);
  assign ccff_head     = head_q;
  assign ccff_shift_en = shen_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// tb/tb_ccff_bitstream_loader.sv - directed-vector bench for ccff_bitstream_loader with a 20-FF chain model.
module tb_ccff_bitstream_loader;

  localparam int L = 20;
  localparam int W = 8;
`ifdef CCFF_READBACK_EN
  localparam int LAT   = L + 3 + 2 + L + 1;
  localparam int EDGES = 2 * L;
`else
  localparam int LAT   = L + 3 + 2;
  localparam int EDGES = L;
`endif

  logic         prog_clk = 1'b0;
  logic         prog_reset_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] word_in = '0;
  logic         word_valid = 1'b0;
  logic         word_ready, ccff_head, ccff_shift_en, ccff_tail, busy, done, error;

  logic [L-1:0] chain = '0;
  logic         fault = 1'b0;
  int           en_cnt = 0;
  int           done_cnt = 0;
  int           n_chk = 0;
  int           n_fail = 0;

  ccff_bitstream_loader #(.CHAIN_LEN(L), .WORD_W(W)) dut (
    .prog_clk      (prog_clk),
    .prog_reset_n  (prog_reset_n),
    .start         (start),
    .word_in       (word_in),
    .word_valid    (word_valid),
    .word_ready    (word_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  always #5 prog_clk = ~prog_clk;

  // Head enters FF L-1, tail is FF 0; optional stuck-at-0 on FF 7.
  assign ccff_tail = chain[0];
  always @(posedge prog_clk) begin
    if (ccff_shift_en) begin
      chain  <= {ccff_head, chain[L-1:1]} & (fault ? 20'hFFF7F : 20'hFFFFF);
      en_cnt <= en_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  typedef struct {
    string        name;
    logic [23:0]  words;
    int           stall;
    int           start_at;
    logic         flt;
    logic [L-1:0] exp_chain;
    int           exp_lat;
    logic         exp_err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_load(input logic [23:0] w, input int stall, input int start_at,
                          output int lat, output logic err_early);
    int   idx;
    int   stall_cnt;
    logic hs;
    idx = 0;
    stall_cnt = 0;
    lat = 0;
    err_early = 1'b0;
    @(negedge prog_clk);
    start = 1'b1;
    for (int c = 0; c < 300; c++) begin
      word_in = (idx < 3) ? w[idx*8 +: 8] : 8'h00;
      if (stall_cnt > 0) begin
        word_valid = 1'b0;
        if (word_ready) stall_cnt--;
      end else begin
        word_valid = (idx < 3);
      end
      hs = word_ready && word_valid;
      @(negedge prog_clk);
      start = 1'b0;
      lat++;
      if (lat == 1) err_early = error;
      if (lat == start_at) start = 1'b1;
      if (hs) begin
        idx++;
        if (idx == 1) stall_cnt = stall;
      end
      if (done) break;
    end
    word_valid = 1'b0;
  endtask

  vec_t vecs[$];
  int   lat;
  int   base_en;
  int   base_done;
  logic err_early;

  initial begin
    vecs.push_back('{name:"basic",   words:24'h093CA5, stall:0, start_at:-1, flt:1'b0, exp_chain:20'h93CA5, exp_lat:LAT,     exp_err:1'b0});
    vecs.push_back('{name:"stall5",  words:24'h093CA5, stall:5, start_at:-1, flt:1'b0, exp_chain:20'h93CA5, exp_lat:LAT + 5, exp_err:1'b0});
    vecs.push_back('{name:"restart", words:24'h093CA5, stall:0, start_at:10, flt:1'b0, exp_chain:20'h93CA5, exp_lat:LAT,     exp_err:1'b0});
    vecs.push_back('{name:"pad",     words:24'hF55AC3, stall:0, start_at:-1, flt:1'b0, exp_chain:20'h55AC3, exp_lat:LAT,     exp_err:1'b0});
    vecs.push_back('{name:"ones",    words:24'h0F00FF, stall:2, start_at:-1, flt:1'b0, exp_chain:20'hF00FF, exp_lat:LAT + 2, exp_err:1'b0});
`ifdef CCFF_READBACK_EN
    vecs.push_back('{name:"fault",   words:24'h0F00FF, stall:0, start_at:-1, flt:1'b1, exp_chain:20'h00000, exp_lat:LAT,     exp_err:1'b1});
    vecs.push_back('{name:"clear",   words:24'h0F00FF, stall:0, start_at:-1, flt:1'b0, exp_chain:20'hF00FF, exp_lat:LAT,     exp_err:1'b0});
`endif

    repeat (3) @(negedge prog_clk);
    chk("rst_word_ready", word_ready, 0);
    chk("rst_head", ccff_head, 0);
    chk("rst_shift_en", ccff_shift_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    prog_reset_n = 1'b1;
    @(negedge prog_clk);

    foreach (vecs[i]) begin
      fault = vecs[i].flt;
      base_en = en_cnt;
      base_done = done_cnt;
      run_load(vecs[i].words, vecs[i].stall, vecs[i].start_at, lat, err_early);
      chk({vecs[i].name, "_latency"}, lat, vecs[i].exp_lat);
      chk({vecs[i].name, "_busy_end"}, busy, 0);
      chk({vecs[i].name, "_error"}, error, vecs[i].exp_err);
      chk({vecs[i].name, "_error_cleared"}, err_early, 0);
      @(negedge prog_clk);
      chk({vecs[i].name, "_done_width"}, done, 0);
      repeat (2) @(negedge prog_clk);
      chk({vecs[i].name, "_edges"}, en_cnt - base_en, EDGES);
      chk({vecs[i].name, "_done_pulses"}, done_cnt - base_done, 1);
      if (!vecs[i].flt) chk({vecs[i].name, "_chain"}, chain, vecs[i].exp_chain);
      fault = 1'b0;
    end

    // word_valid in IDLE must not be accepted
    base_en = en_cnt;
    word_in = 8'hFF;
    word_valid = 1'b1;
    repeat (4) @(negedge prog_clk);
    chk("idle_word_ready", word_ready, 0);
    chk("idle_busy", busy, 0);
    chk("idle_edges", en_cnt - base_en, 0);
    word_valid = 1'b0;

    // reset at bit 10 of a load
    base_en = en_cnt;
    start = 1'b1;
    word_in = 8'hA5;
    word_valid = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (en_cnt - base_en >= 10) break;
      @(negedge prog_clk);
    end
    chk("mid_progress", en_cnt - base_en, 10);
    chk("mid_shift_en", ccff_shift_en, 1);
    prog_reset_n = 1'b0;
    @(negedge prog_clk);
    chk("mid_rst_word_ready", word_ready, 0);
    chk("mid_rst_head", ccff_head, 0);
    chk("mid_rst_shift_en", ccff_shift_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_error", error, 0);
    prog_reset_n = 1'b1;
    word_valid = 1'b0;
    @(negedge prog_clk);
    base_en = en_cnt;
    run_load(24'h093CA5, 0, -1, lat, err_early);
    chk("reload_latency", lat, LAT);
    repeat (2) @(negedge prog_clk);
    chk("reload_edges", en_cnt - base_en, EDGES);
    chk("reload_chain", chain, 20'h93CA5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
